// File: rtl/pulse_divider.sv
// Programmable event prescaler: one-clock pulse on every Nth rising edge of inputPulse,
// continuous or one-shot. Define PULSE_DIV_SYNC_EN to add a 2-flop input synchroniser.
module pulse_divider #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             oneShot,
    input  logic             start,
    input  logic [CNT_W-1:0] divisor,
    input  logic             inputPulse,
    output logic             outputPulse,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } stateT;

    stateT            stateReg,  stateNext;
    logic [CNT_W-1:0] countReg,  countNext;
    logic [CNT_W-1:0] divLatReg, divLatNext;
    logic             pulseReg,  pulseNext;
    logic             inPrevReg;
    logic             inS;
    logic             evt;
    logic [CNT_W-1:0] divEff;

`ifdef PULSE_DIV_SYNC_EN
    // Sync flops reset high so a source held high through reset never looks like an edge.
    logic [1:0] syncReg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncReg <= 2'b11;
        end else begin
            syncReg <= {syncReg[0], inputPulse};
        end
    end

    assign inS = syncReg[1];
`else
    assign inS = inputPulse;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inPrevReg <= 1'b1;
        end else begin
            inPrevReg <= inS;
        end
    end

    assign evt    = inS & ~inPrevReg;
    assign divEff = (divisor == '0) ? CNT_W'(DEFAULT_DIV) : divisor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg  <= IDLE;
            countReg  <= '0;
            divLatReg <= CNT_W'(DEFAULT_DIV);
            pulseReg  <= 1'b0;
        end else begin
            stateReg  <= stateNext;
            countReg  <= countNext;
            divLatReg <= divLatNext;
            pulseReg  <= pulseNext;
        end
    end

    always_comb begin
        stateNext  = stateReg;
        countNext  = countReg;
        divLatNext = divLatReg;
        pulseNext  = 1'b0;

        if (!enable) begin
            stateNext = IDLE;
            countNext = '0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (!oneShot || start) begin
                        stateNext  = RUN;
                        countNext  = '0;
                        divLatNext = divEff;
                    end
                end
                RUN: begin
                    // A restart strobe wins over an event arriving in the same cycle.
                    if (oneShot && start) begin
                        countNext  = '0;
                        divLatNext = divEff;
                    end else if (evt) begin
                        if (countReg == divLatReg - CNT_W'(1)) begin
                            countNext = '0;
                            pulseNext = 1'b1;
                            if (oneShot) begin
                                stateNext = HOLD;
                            end else begin
                                divLatNext = divEff;
                            end
                        end else begin
                            countNext = countReg + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (oneShot && start) begin
                        stateNext  = RUN;
                        countNext  = '0;
                        divLatNext = divEff;
                    end
                end
                default: begin
                    stateNext = IDLE;
                    countNext = '0;
                end
            endcase
        end
    end

    assign outputPulse = pulseReg;
    assign count       = countReg;
    assign busy        = (stateReg == RUN);
    assign done        = (stateReg == HOLD);

endmodule
